// File: rtl/ahb_to_avalon_bridge_pkg.sv
// ahb_avalon_pkg: AHB encodings and bridge FSM states shared by the AHB-to-Avalon bridge files
package ahb_avalon_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;
  localparam logic [2:0] HSIZE_DWORD   = 3'd3;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
  typedef enum logic [2:0] {IDLE, WR, RD_CMD, RD_WAIT, ERR1, ERR2} bridge_state_t;
endpackage

// File: rtl/ahb_to_avalon_bridge_if.sv
// ahb_to_avalon_bridge_if: AHB-Lite slave side plus Avalon-MM master side; modport slave = bridge view, master = driver/slave-model view
interface ahb_to_avalon_bridge_if #(parameter int AW = 32, parameter int DW = 32);
  logic            hsel;
  logic [AW-1:0]   haddr;
  logic [1:0]      htrans;
  logic [2:0]      hsize;
  logic            hwrite;
  logic [DW-1:0]   hwdata;
  logic            hready;
  logic            hreadyout;
  logic            hresp;
  logic [DW-1:0]   hrdata;
  logic [AW-1:0]   avm_address;
  logic            avm_read;
  logic            avm_write;
  logic [DW-1:0]   avm_writedata;
  logic [DW/8-1:0] avm_byteenable;
  logic            avm_waitrequest;
  logic [DW-1:0]   avm_readdata;
  logic            avm_readdatavalid;
  modport slave (
    input  hsel, haddr, htrans, hsize, hwrite, hwdata, hready,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output hreadyout, hresp, hrdata,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );
  modport master (
    output hsel, haddr, htrans, hsize, hwrite, hwdata, hready,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  hreadyout, hresp, hrdata,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/ahb_to_avalon_bridge_byteen_decode.sv
// ahb_byteen_decode: hsize + low address bits -> byteenable lanes and misaligned/oversize err flag (combinational)
module ahb_byteen_decode #(
  parameter int DW = 32,
  localparam int NB = DW / 8,
  localparam int LB = $clog2(NB)
) (
  input  logic [2:0]    hsize,
  input  logic [LB-1:0] addr_lo,
  output logic [NB-1:0] byteenable,
  output logic          err
);
  logic [NB-1:0] lanes;
  logic [LB-1:0] mask;
  assign lanes      = NB'((32'd1 << (32'd1 << hsize)) - 32'd1);
  assign mask       = LB'((32'd1 << hsize) - 32'd1);
  assign byteenable = lanes << addr_lo;
  assign err        = (hsize > 3'(LB)) || |(addr_lo & mask);
endmodule

// File: rtl/ahb_to_avalon_bridge.sv
// ahb_to_avalon_bridge: AHB-Lite slave (hclk, async hreset, bus.slave) turning each beat into one Avalon-MM read/write
module ahb_to_avalon_bridge
  import ahb_avalon_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic hclk,
  input logic hreset,
  ahb_to_avalon_bridge_if.slave bus
);
  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  bridge_state_t state;
  logic [NB-1:0] be;
  logic err, cap;
  ahb_byteen_decode #(.DW(DW)) u_dec (
    .hsize(bus.hsize),
    .addr_lo(bus.haddr[LB-1:0]),
    .byteenable(be),
    .err(err)
  );
  assign cap = bus.hsel && bus.hready && (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ) &&
               (state == IDLE || state == ERR2);
  assign bus.avm_writedata = bus.hwdata;
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state              <= IDLE;
      bus.hreadyout      <= 1'b1;
      bus.hresp          <= HRESP_OKAY;
      bus.hrdata         <= '0;
      bus.avm_read       <= 1'b0;
      bus.avm_write      <= 1'b0;
      bus.avm_address    <= '0;
      bus.avm_byteenable <= '0;
    end else if (cap) begin
      bus.avm_address    <= {bus.haddr[AW-1:LB], LB'(0)};
      bus.avm_byteenable <= be;
      bus.hreadyout      <= 1'b0;
      bus.hresp          <= err ? HRESP_ERROR : HRESP_OKAY;
      bus.avm_write      <= !err && bus.hwrite;
      bus.avm_read       <= !err && !bus.hwrite;
      state              <= err ? ERR1 : bus.hwrite ? WR : RD_CMD;
    end else begin
      case (state)
        WR: if (!bus.avm_waitrequest) begin
          bus.avm_write <= 1'b0;
          bus.hreadyout <= 1'b1;
          state         <= IDLE;
        end
        RD_CMD: if (!bus.avm_waitrequest) begin
          bus.avm_read <= 1'b0;
          state        <= RD_WAIT;
        end
        RD_WAIT: if (bus.avm_readdatavalid) begin
          bus.hrdata    <= bus.avm_readdata;
          bus.hreadyout <= 1'b1;
          state         <= IDLE;
        end
        ERR1: begin
          bus.hreadyout <= 1'b1;
          state         <= ERR2;
        end
        ERR2: begin
          bus.hresp <= HRESP_OKAY;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_to_avalon_bridge.sv
// tb_ahb_to_avalon_bridge: directed self-checking bench for the AHB-to-Avalon bridge
module tb_ahb_to_avalon_bridge;
  import ahb_avalon_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  ahb_to_avalon_bridge_if #(.AW(32), .DW(32)) bus ();
  ahb_to_avalon_bridge #(.AW(32), .DW(32)) dut (.hclk(clk), .hreset(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.hready = bus.hreadyout;
  task automatic drive(input logic [31:0] a, input logic [2:0] sz, input logic wr, input logic [1:0] tr);
    bus.hsel   = 1'b1;
    bus.haddr  = a;
    bus.hsize  = sz;
    bus.hwrite = wr;
    bus.htrans = tr;
  endtask
  task automatic test_reset;
    @(negedge clk);
    tests++;
    if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0 || bus.hrdata !== 32'h0 || bus.avm_read !== 1'b0 ||
        bus.avm_write !== 1'b0 || bus.avm_address !== 32'h0 || bus.avm_byteenable !== 4'h0) begin
      fails++;
      $display("FAIL reset_values: rdy=%b resp=%b rdata=%h rd=%b wr=%b addr=%h be=%h, required 1 0 0 0 0 0 0",
               bus.hreadyout, bus.hresp, bus.hrdata, bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_byteenable);
    end
    rst = 1'b0;
  endtask
  task automatic test_word_write;
    int lo = 0, wc = 0;
    drive(32'h100, HSIZE_WORD, 1'b1, HTRANS_NONSEQ);
    bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    bus.htrans = HTRANS_IDLE;
    bus.hwdata = 32'hDEADBEEF;
    #1;
    tests++;
    if (bus.avm_write !== 1'b1 || bus.avm_address !== 32'h100 || bus.avm_byteenable !== 4'hF || bus.avm_writedata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL word_write_cmd: wr=%b addr=%h be=%h wdata=%h, required 1 100 f deadbeef",
               bus.avm_write, bus.avm_address, bus.avm_byteenable, bus.avm_writedata);
    end
    for (int i = 0; i < 20 && bus.hreadyout === 1'b0; i++) begin
      lo++;
      if (bus.avm_write) wc++;
      if (bus.hresp !== 1'b0) lo += 100;
      @(negedge clk);
    end
    tests++;
    if (lo !== 1 || wc !== 1 || bus.avm_write !== 1'b0) begin
      fails++;
      $display("FAIL word_write_timing: lo=%0d wr_cycles=%0d wr_after=%b, required 1 1 0", lo, wc, bus.avm_write);
    end
  endtask
  task automatic test_byte_write;
    int lo = 0, wc = 0;
    drive(32'h103, HSIZE_BYTE, 1'b1, HTRANS_NONSEQ);
    bus.avm_waitrequest = 1'b1;
    @(negedge clk);
    bus.htrans = HTRANS_IDLE;
    bus.hwdata = 32'hAA000000;
    tests++;
    if (bus.avm_byteenable !== 4'h8 || bus.avm_address !== 32'h100) begin
      fails++;
      $display("FAIL byte_write_cmd: be=%h addr=%h, required 8 100", bus.avm_byteenable, bus.avm_address);
    end
    for (int i = 0; i < 20 && bus.hreadyout === 1'b0; i++) begin
      lo++;
      if (bus.avm_write) wc++;
      if (i == 3) bus.avm_waitrequest = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (lo !== 4 || wc !== 4 || bus.hresp !== 1'b0) begin
      fails++;
      $display("FAIL byte_write_stall: lo=%0d wr_cycles=%0d resp=%b, required 4 4 0", lo, wc, bus.hresp);
    end
  endtask
  task automatic test_word_read;
    int lo = 0, rc = 0;
    drive(32'h40, HSIZE_WORD, 1'b0, HTRANS_NONSEQ);
    bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    bus.htrans = HTRANS_IDLE;
    tests++;
    if (bus.avm_read !== 1'b1 || bus.avm_address !== 32'h40 || bus.avm_write !== 1'b0) begin
      fails++;
      $display("FAIL word_read_cmd: rd=%b addr=%h wr=%b, required 1 40 0", bus.avm_read, bus.avm_address, bus.avm_write);
    end
    for (int i = 0; i < 20 && bus.hreadyout === 1'b0; i++) begin
      lo++;
      if (bus.avm_read) rc++;
      bus.avm_readdatavalid = (i == 2);
      bus.avm_readdata = (i == 2) ? 32'h12345678 : 32'hFFFFFFFF;
      @(negedge clk);
    end
    bus.avm_readdatavalid = 1'b0;
    tests++;
    if (bus.hrdata !== 32'h12345678 || bus.hresp !== 1'b0 || lo !== 3 || rc !== 1) begin
      fails++;
      $display("FAIL word_read_data: hrdata=%h resp=%b lo=%0d rd_cycles=%0d, required 12345678 0 3 1", bus.hrdata, bus.hresp, lo, rc);
    end
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata = 32'h0BADF00D;
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    tests++;
    if (bus.hrdata !== 32'h12345678 || bus.hreadyout !== 1'b1) begin
      fails++;
      $display("FAIL stray_rdv_ignored: hrdata=%h rdy=%b, required 12345678 1", bus.hrdata, bus.hreadyout);
    end
  endtask
  task automatic test_errors;
    logic [31:0] a [2] = '{32'h201, 32'h200};
    logic [2:0] s [2] = '{HSIZE_HALF, HSIZE_DWORD};
    logic w [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      drive(a[k], s[k], w[k], HTRANS_NONSEQ);
      @(negedge clk);
      bus.htrans = HTRANS_IDLE;
      tests++;
      if (bus.hreadyout !== 1'b0 || bus.hresp !== 1'b1 || bus.avm_read !== 1'b0 || bus.avm_write !== 1'b0) begin
        fails++;
        $display("FAIL err%0d_first: rdy=%b resp=%b rd=%b wr=%b, required 0 1 0 0", k, bus.hreadyout, bus.hresp, bus.avm_read, bus.avm_write);
      end
      @(negedge clk);
      tests++;
      if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b1 || bus.avm_read !== 1'b0 || bus.avm_write !== 1'b0) begin
        fails++;
        $display("FAIL err%0d_second: rdy=%b resp=%b rd=%b wr=%b, required 1 1 0 0", k, bus.hreadyout, bus.hresp, bus.avm_read, bus.avm_write);
      end
      @(negedge clk);
      tests++;
      if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin
        fails++;
        $display("FAIL err%0d_after: rdy=%b resp=%b, required 1 0", k, bus.hreadyout, bus.hresp);
      end
    end
  endtask
  task automatic test_back_to_back;
    drive(32'h10, HSIZE_WORD, 1'b1, HTRANS_NONSEQ);
    bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    bus.hwdata = 32'h55AA55AA;
    drive(32'h14, HSIZE_WORD, 1'b0, HTRANS_NONSEQ);
    tests++;
    if (bus.avm_write !== 1'b1 || bus.avm_address !== 32'h10 || bus.hreadyout !== 1'b0) begin
      fails++;
      $display("FAIL b2b_write: wr=%b addr=%h rdy=%b, required 1 10 0", bus.avm_write, bus.avm_address, bus.hreadyout);
    end
    @(negedge clk);
    tests++;
    if (bus.hreadyout !== 1'b1 || bus.avm_write !== 1'b0 || bus.avm_read !== 1'b0) begin
      fails++;
      $display("FAIL b2b_completion: rdy=%b wr=%b rd=%b, required 1 0 0", bus.hreadyout, bus.avm_write, bus.avm_read);
    end
    @(negedge clk);
    bus.htrans = HTRANS_IDLE;
    tests++;
    if (bus.avm_read !== 1'b1 || bus.avm_address !== 32'h14 || bus.hreadyout !== 1'b0) begin
      fails++;
      $display("FAIL b2b_read_start: rd=%b addr=%h rdy=%b, required 1 14 0", bus.avm_read, bus.avm_address, bus.hreadyout);
    end
    @(negedge clk);
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata = 32'hA5A5_0014;
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    tests++;
    if (bus.hreadyout !== 1'b1 || bus.hrdata !== 32'hA5A50014) begin
      fails++;
      $display("FAIL b2b_read_done: rdy=%b hrdata=%h, required 1 a5a50014", bus.hreadyout, bus.hrdata);
    end
  endtask
  task automatic test_idle_busy;
    int act = 0;
    logic [1:0] tr [3] = '{HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ};
    for (int k = 0; k < 3; k++) begin
      drive(32'h300, HSIZE_WORD, 1'b1, tr[k]);
      if (k == 2) bus.hsel = 1'b0;
      @(negedge clk);
      if (bus.avm_read || bus.avm_write || !bus.hreadyout || bus.hresp) act++;
    end
    bus.htrans = HTRANS_IDLE;
    tests++;
    if (act !== 0) begin
      fails++;
      $display("FAIL idle_busy_nosel: active_cycles=%0d, required 0", act);
    end
  endtask
  task automatic test_reset_rd_wait;
    drive(32'h80, HSIZE_WORD, 1'b0, HTRANS_NONSEQ);
    bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    bus.htrans = HTRANS_IDLE;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    tests++;
    if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0 || bus.hrdata !== 32'h0 || bus.avm_read !== 1'b0 ||
        bus.avm_write !== 1'b0 || bus.avm_address !== 32'h0 || bus.avm_byteenable !== 4'h0) begin
      fails++;
      $display("FAIL async_reset: rdy=%b resp=%b rdata=%h rd=%b wr=%b addr=%h be=%h, required 1 0 0 0 0 0 0",
               bus.hreadyout, bus.hresp, bus.hrdata, bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_byteenable);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata = 32'hDEAD0BAD;
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    tests++;
    if (bus.hrdata !== 32'h0 || bus.hreadyout !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_rdv: hrdata=%h rdy=%b, required 0 1", bus.hrdata, bus.hreadyout);
    end
    drive(32'h86, HSIZE_HALF, 1'b0, HTRANS_NONSEQ);
    @(negedge clk);
    bus.htrans = HTRANS_IDLE;
    tests++;
    if (bus.avm_read !== 1'b1 || bus.avm_address !== 32'h84 || bus.avm_byteenable !== 4'hC) begin
      fails++;
      $display("FAIL post_reset_cmd: rd=%b addr=%h be=%h, required 1 84 c", bus.avm_read, bus.avm_address, bus.avm_byteenable);
    end
    @(negedge clk);
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    tests++;
    if (bus.hrdata !== 32'hCAFEF00D || bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_read: hrdata=%h rdy=%b resp=%b, required cafef00d 1 0", bus.hrdata, bus.hreadyout, bus.hresp);
    end
  endtask
  initial begin
    bus.hsel = 1'b0;
    bus.haddr = '0;
    bus.htrans = HTRANS_IDLE;
    bus.hsize = HSIZE_WORD;
    bus.hwrite = 1'b0;
    bus.hwdata = '0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata = '0;
    bus.avm_readdatavalid = 1'b0;
    test_reset();
    test_word_write();
    test_byte_write();
    test_word_read();
    test_errors();
    test_back_to_back();
    test_idle_busy();
    test_reset_rd_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ahb_to_avalon_bridge.md
Name: ahb_to_avalon_bridge

Overview:
- AHB-Lite slave that accepts transfers from the AHB master driver/VIP and converts each one into a single Avalon-MM master read or write.
- Sits directly downstream of the AHB master, in front of Avalon-MM slaves.
- Non-bursting: each AHB beat becomes one Avalon command with at most one outstanding.
- hburst/hprot are not used.

Parameters:
- AW, 32, address width for haddr and avm_address (byte address).
- DW, 32, data width; legal values 32 or 64; byteenable width is DW/8.

Ports:
- hclk  in  1  clock
- hreset  in  1  asynchronous active-high reset
- hsel  in  1  slave select
- haddr  in  AW  AHB address
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hsize  in  3  transfer size, log2 bytes
- hwrite  in  1  1 = write
- hwdata  in  DW  write data, valid in data phase
- hready  in  1  bus-level ready
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- hrdata  out  DW  read data, registered
- avm_address  out  AW  byte address, aligned to DW/8
- avm_read  out  1  read command
- avm_write  out  1  write command
- avm_writedata  out  DW  write data
- avm_byteenable  out  DW/8  byte lanes
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DW  read data
- avm_readdatavalid  in  1  read data strobe

Behaviour:
- Clock and reset: one clock, hclk. Reset hreset is asynchronous and active-high.
- Reset values: hreadyout=1, hresp=0, hrdata=0, avm_read=0, avm_write=0, avm_address=0, avm_byteenable=0, state=IDLE.
- Reset mid-operation aborts the transfer immediately. Any Avalon command is dropped and no response is pending after release.
- Capture condition: in IDLE, when hsel & hready & htrans[1]. On that edge the block registers haddr, hsize and hwrite, sets hreadyout<=0 and moves to the next state:
  - ERR1 if hsize > log2(DW/8), or if haddr is misaligned to hsize.
  - Otherwise WR if hwrite, RD_CMD if not.
- htrans IDLE/BUSY while selected, or hsel=0: no action. OKAY with zero wait states; hreadyout stays 1.
- Byte enables, decoded once at capture:
  - byte: 1 << haddr[lsb]
  - halfword: 2'b11 << (2*haddr[lsb:1])
  - word: 4'hF << (4*haddr[2]) when DW=64
  - full DW: all ones
- avm_address = haddr with the low log2(DW/8) bits cleared.
- WR state: avm_write=1 and avm_writedata=hwdata (combinational pass-through; stable because the data phase is stalled). Held until avm_waitrequest=0. On that edge: avm_write<=0, hreadyout<=1, state<=IDLE.
  - Minimum: one AHB wait state.
- RD_CMD state: avm_read=1, held until avm_waitrequest=0. On that edge: avm_read<=0, state<=RD_WAIT.
- RD_WAIT state: wait for avm_readdatavalid, which is never asserted in the acceptance cycle. On that edge: hrdata<=avm_readdata, hreadyout<=1, state<=IDLE.
  - Minimum: two AHB wait states.
  - readdatavalid outside RD_WAIT is ignored.
- ERR1: hreadyout=0, hresp=1, one cycle, then ERR2.
- ERR2: hreadyout=1, hresp=1, then IDLE with hresp<=0.
  - No Avalon activity for an errored transfer.
- hresp is 0 in every state except ERR1 and ERR2.
- hrdata holds its last value between reads.
- Pipelining: the cycle in which hreadyout returns to 1 is also an address phase. A new transfer is captured on that edge with no bubble.
- Timeout: none. An indefinite avm_waitrequest stalls AHB indefinitely.

Decomposition:
- Shared package ahb_avalon_pkg holds:
  - HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ
  - HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD, HSIZE_DWORD
  - HRESP_OKAY, HRESP_ERROR
  - bridge state encoding: IDLE, WR, RD_CMD, RD_WAIT, ERR1, ERR2
- One sub-module, ahb_byteen_decode: combinational; inputs hsize and haddr low bits; outputs byteenable and a misaligned/oversize error flag.

Test Plan:
- Word write: haddr=0x100, hwdata=0xDEADBEEF, waitrequest=0.
  - Expect avm_write=1 for 1 cycle with address 0x100, byteenable 4'hF.
  - hreadyout low for 1 cycle; hresp=0.
- Byte write: haddr=0x103, hsize=0, waitrequest high for 3 cycles.
  - Expect byteenable 4'h8, address 0x100, avm_write held for 4 cycles.
  - hreadyout low for 4 cycles.
- Word read: haddr=0x40, slave returns readdatavalid 2 cycles after accept with 0x12345678.
  - Expect hrdata=0x12345678 when hreadyout rises; hresp=0.
- Errors: misaligned halfword at haddr=0x201, and hsize=3 with DW=32.
  - Expect the two-cycle ERROR: hreadyout 0 then 1, hresp=1 in both cycles.
  - Expect no avm_read or avm_write.
- Back-to-back: NONSEQ write 0x10 followed by NONSEQ read 0x14 in the completion cycle.
  - Expect the read command to start the cycle after the write completes; no lost transfer.
  - IDLE/BUSY htrans produce no Avalon activity.
- Reset in RD_WAIT: assert hreset.
  - Expect outputs to reach reset values asynchronously.
  - A later readdatavalid is ignored; the next transfer completes normally.
